// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared encodings and helpers for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {RUN, MWAIT} state_t;

    // Width-generic saturating increment; callers cast the result back to their own width.
    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max;
        max = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v == max) ? v : v + 64'd1;
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: EX operand bypass select and data mux; MEM beats WB, x0 is never bypassed.
module fwd_mux import pipe_ctrl_pkg::*; #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [XLEN-1:0]   reg_val,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [XLEN-1:0]   mem_data,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [XLEN-1:0]   wb_data,
    output logic [1:0]        sel,
    output logic [XLEN-1:0]   data
);

    assign sel  = (src == '0) ? FWD_REG :
                  (mem_regwrite && mem_rd == src) ? FWD_MEM :
                  (wb_regwrite && wb_rd == src) ? FWD_WB : FWD_REG;
    assign data = (sel == FWD_MEM) ? mem_data :
                  (sel == FWD_WB) ? wb_data :
                  (sel == FWD_REG) ? reg_val : '0;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stage enables/flushes, EX forwarding, memory-wait freeze with watchdog,
// and saturating stall/flush counters for the 5-stage pipeline.
module pipe_hazard_ctrl import pipe_ctrl_pkg::*; #(
    parameter int XLEN        = 32,
    parameter int REG_AW      = 5,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_is_load,
    input  logic              ex_redirect,
    input  logic [XLEN-1:0]   ex_rs1_reg,
    input  logic [XLEN-1:0]   ex_rs2_reg,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [XLEN-1:0]   mem_aluout,
    input  logic              mem_req,
    input  logic              mem_ready,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [XLEN-1:0]   wb_wdata,
    input  logic              cnt_clr,
    input  logic              err_clr,
    output logic              pc_en,
    output logic              if_id_en,
    output logic              if_id_flush,
    output logic              id_ex_en,
    output logic              id_ex_flush,
    output logic              ex_mem_en,
    output logic              mem_wb_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic              mem_timeout,
    output logic              mem_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wd;
    logic            wd_hit, timeout, freeze, redirect, load_use;

    assign wd_hit   = (state == MWAIT) && (wd == TO_W'(MEM_TIMEOUT - 1));
    assign timeout  = wd_hit & ~mem_ready;
    assign freeze   = (state == RUN) ? (mem_req & ~mem_ready) : (~mem_ready & ~wd_hit);
    // A redirect seen while frozen is simply held in EX and acted on at release.
    assign redirect = ~freeze & ex_redirect;
    assign load_use = ~freeze & ~ex_redirect & ex_is_load & (ex_rd != '0) &
                      ((ex_rd == id_rs1 & id_use_rs1) | (ex_rd == id_rs2 & id_use_rs2));

    assign pc_en         = ~freeze & ~load_use;
    assign if_id_en      = ~freeze & ~load_use;
    assign if_id_flush   = redirect;
    assign id_ex_en      = ~freeze;
    assign id_ex_flush   = redirect | load_use;
    assign ex_mem_en     = ~freeze;
    assign mem_wb_bubble = freeze;

    always_comb begin
        state_nxt = state;
        state_nxt = (state == RUN) ? ((mem_req & ~mem_ready) ? MWAIT : RUN)
                                   : ((mem_ready | wd_hit) ? RUN : MWAIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            wd          <= '0;
            mem_timeout <= 1'b0;
            mem_err     <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state       <= state_nxt;
            wd          <= (state == MWAIT && state_nxt == MWAIT) ? wd + TO_W'(1) : '0;
            mem_timeout <= timeout;
            mem_err     <= timeout | (mem_err & ~err_clr);
            stall_cnt   <= cnt_clr ? '0 : (freeze | load_use) ? CNT_W'(sat_inc(64'(stall_cnt), CNT_W)) : stall_cnt;
            flush_cnt   <= cnt_clr ? '0 : redirect ? CNT_W'(sat_inc(64'(flush_cnt), CNT_W)) : flush_cnt;
        end
    end

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_a (
        .src(ex_rs1), .reg_val(ex_rs1_reg),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_data(mem_aluout),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_wdata),
        .sel(fwd_a_sel), .data(ex_op_a)
    );

    fwd_mux #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd_b (
        .src(ex_rs2), .reg_val(ex_rs2_reg),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_data(mem_aluout),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_data(wb_wdata),
        .sel(fwd_b_sel), .data(ex_op_b)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: random stimulus against a priority-table reference model.
module tb_pipe_hazard_ctrl;

    localparam int T = 4;
    localparam int CW = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_is_load, ex_redirect, mem_regwrite, mem_req, mem_ready;
    logic wb_regwrite, cnt_clr, err_clr;
    logic [31:0] ex_rs1_reg, ex_rs2_reg, mem_aluout, wb_wdata, ex_op_a, ex_op_b;
    logic pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic mem_timeout, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0, errors = 0;
    int n = 0, m_stall = 0, m_flush = 0;
    bit m_to = 0, m_err = 0, fr, rd, lu;
    logic [6:0] exp_ctl;
    logic [33:0] fa, fb;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.XLEN(32), .REG_AW(5), .TO_W(8), .MEM_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_is_load(ex_is_load),
        .ex_redirect(ex_redirect), .ex_rs1_reg(ex_rs1_reg), .ex_rs2_reg(ex_rs2_reg),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_aluout(mem_aluout),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_wdata(wb_wdata),
        .cnt_clr(cnt_clr), .err_clr(err_clr),
        .pc_en(pc_en), .if_id_en(if_id_en), .if_id_flush(if_id_flush),
        .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush), .ex_mem_en(ex_mem_en),
        .mem_wb_bubble(mem_wb_bubble), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .mem_timeout(mem_timeout), .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [33:0] fwd_ref(input logic [4:0] s, input logic [31:0] r);
        if (s == 0) return {2'b00, r};
        if (mem_regwrite && mem_rd == s) return {2'b10, mem_aluout};
        if (wb_regwrite && wb_rd == s) return {2'b01, wb_wdata};
        return {2'b00, r};
    endfunction

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? v : v + 1;
    endfunction

    task automatic drive_random();
        id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
        ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
        ex_rd = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
        wb_rd = 5'($urandom_range(0, 3));
        id_use_rs1 = 1'($urandom); id_use_rs2 = 1'($urandom);
        ex_is_load = 1'($urandom); ex_redirect = ($urandom_range(0, 4) == 0);
        mem_regwrite = 1'($urandom); wb_regwrite = 1'($urandom);
        mem_req = 1'($urandom); mem_ready = ($urandom_range(0, 9) >= 4);
        cnt_clr = ($urandom_range(0, 399) == 0); err_clr = ($urandom_range(0, 14) == 0);
        ex_rs1_reg = $urandom; ex_rs2_reg = $urandom; mem_aluout = $urandom; wb_wdata = $urandom;
    endtask

    task automatic check_outputs();
        // n counts frozen cycles in the current memory-wait episode
        fr = (n > 0) ? (!mem_ready && n < T) : (mem_req && !mem_ready);
        rd = !fr && ex_redirect;
        lu = !fr && !ex_redirect && ex_is_load && ex_rd != 0 &&
             ((ex_rd == id_rs1 && id_use_rs1) || (ex_rd == id_rs2 && id_use_rs2));
        // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}
        exp_ctl = fr ? 7'b0000001 : rd ? 7'b1111110 : lu ? 7'b0001110 : 7'b1101010;
        chk("ctl", {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_bubble}, exp_ctl);
        fa = fwd_ref(ex_rs1, ex_rs1_reg);
        fb = fwd_ref(ex_rs2, ex_rs2_reg);
        chk("fwd_a", {fwd_a_sel, ex_op_a}, fa);
        chk("fwd_b", {fwd_b_sel, ex_op_b}, fb);
        chk("mem_timeout", mem_timeout, m_to);
        chk("mem_err", mem_err, m_err);
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic update_model();
        m_to = (n > 0) && !mem_ready && n == T;
        m_err = m_to || (m_err && !err_clr);
        m_stall = cnt_clr ? 0 : (fr || lu) ? sat(m_stall) : m_stall;
        m_flush = cnt_clr ? 0 : rd ? sat(m_flush) : m_flush;
        n = fr ? n + 1 : 0;
    endtask

    initial begin
        drive_random();
        mem_req = 0; ex_redirect = 0; ex_is_load = 0; cnt_clr = 0; err_clr = 0;
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive_random();
            #1;
            check_outputs();
            @(posedge clk);
            update_model();
        end
        // reset asserted in the middle of a memory wait
        @(negedge clk);
        mem_req = 1; mem_ready = 0; ex_redirect = 0; ex_is_load = 0; cnt_clr = 0; err_clr = 0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        mem_req = 0;
        #1;
        n = 0; m_to = 0; m_err = 0; m_stall = 0; m_flush = 0;
        check_outputs();
        chk("rst_ctl_run", {pc_en, id_ex_en, mem_wb_bubble}, 3'b110);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Centralised, parametrised hazard controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). It replaces the separate hazard-detect and forwarding units with one block. The block does the following:
- generates per-stage enable/flush controls and EX operand forwarding (select and data);
- adds a memory-wait freeze FSM driven by MIO_ready handshake, with a watchdog timeout;
- keeps saturating stall/flush performance counters.

Parameters:
XLEN, 32, datapath width of forwarded operands
REG_AW, 5, register index width
TO_W, 8, width of memory-wait watchdog counter
MEM_TIMEOUT, 200, wait cycles before forced release (must be less than 2**TO_W)
CNT_W, 32, perf counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_use_rs1  in  1  ID instr reads rs1
id_use_rs2  in  1  ID instr reads rs2
ex_rs1  in  REG_AW  EX source 1
ex_rs2  in  REG_AW  EX source 2
ex_rd  in  REG_AW  EX destination
ex_is_load  in  1  EX instr is a load
ex_redirect  in  1  EX branch taken / jump
ex_rs1_reg  in  XLEN  EX rs1 value from ID/EX register
ex_rs2_reg  in  XLEN  EX rs2 value from ID/EX register
mem_rd  in  REG_AW  MEM destination
mem_regwrite  in  1  MEM writes register
mem_aluout  in  XLEN  MEM ALU result
mem_req  in  1  MEM stage performs a load/store this cycle
mem_ready  in  1  memory handshake ready (MIO_ready)
wb_rd  in  REG_AW  WB destination
wb_regwrite  in  1  WB writes register
wb_wdata  in  XLEN  WB write-back data
cnt_clr  in  1  clear perf counters
err_clr  in  1  clear sticky timeout flag
pc_en  out  1  PC update enable
if_id_en  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID flush
id_ex_en  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX bubble
ex_mem_en  out  1  EX/MEM load enable
mem_wb_bubble  out  1  MEM/WB loads a bubble (regwrite=0)
fwd_a_sel  out  2  rs1 forward select
fwd_b_sel  out  2  rs2 forward select
ex_op_a  out  XLEN  forwarded rs1 value
ex_op_b  out  XLEN  forwarded rs2 value
mem_timeout  out  1  one-cycle pulse on watchdog release
mem_err  out  1  sticky timeout flag
stall_cnt  out  CNT_W  stall cycles
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Reset (rst_n=0): state=RUN, watchdog=0, mem_err=0, mem_timeout=0, stall_cnt=0, flush_cnt=0. Combinational outputs follow the rules below with state=RUN.
- FSM states:
  - RUN: mem_req & ~mem_ready → MWAIT.
  - MWAIT: mem_ready → RUN. Otherwise, watchdog==MEM_TIMEOUT-1 → RUN with mem_timeout=1 and mem_err set. Otherwise watchdog++.
  - Watchdog clears on every entry to RUN.
- freeze = (RUN & mem_req & ~mem_ready) | (MWAIT & ~mem_ready & ~wd_hit). Evaluated combinationally the same cycle.
- Priority: freeze > redirect > load-use > normal.
- Freeze: pc_en=if_id_en=id_ex_en=ex_mem_en=0, all flushes 0, mem_wb_bubble=1. An ex_redirect during freeze is not acted on. EX is held, so the redirect is applied on the release cycle.
- Redirect (not frozen): pc_en=1, if_id_flush=1, id_ex_flush=1, all enables 1. flush_cnt increments.
- Load-use (not frozen, no redirect): condition is ex_is_load & ex_rd!=0 & ((ex_rd==id_rs1 & id_use_rs1) | (ex_rd==id_rs2 & id_use_rs2)). Response: pc_en=0, if_id_en=0, id_ex_flush=1. Exactly one bubble.
- Normal: all enables 1, flushes 0, mem_wb_bubble=0.
- stall_cnt increments on freeze or load-use cycles. Both counters saturate at all-ones. cnt_clr takes priority over increment.
- Forwarding (per operand, x0 never forwarded):
  - 2'b10 = mem_aluout when mem_regwrite & mem_rd==src & src!=0;
  - else 2'b01 = wb_wdata when wb_regwrite & wb_rd==src & src!=0;
  - else 2'b00 = register value. 2'b11 is unused and yields 0.
  - MEM beats WB.
- mem_err: set on timeout, cleared by err_clr. Set wins if both occur in the same cycle.
- mem_timeout and mem_err are registered outputs.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - FWD_REG/FWD_WB/FWD_MEM codes;
  - FSM state encoding (RUN, MWAIT);
  - saturating-increment function.
- Sub-module fwd_mux: one per operand, performs the select compare and data mux, parametrised by XLEN/REG_AW.

Test Plan:
1. Load-use: ex_is_load=1, ex_rd=5, id_rs1=5, id_use_rs1=1 → pc_en=0, if_id_en=0, id_ex_flush=1 for one cycle; stall_cnt=1.
2. Forward priority: mem_rd=wb_rd=ex_rs1=7, both regwrite=1 → fwd_a_sel=2'b10, ex_op_a=mem_aluout. With ex_rs1=0 → fwd_a_sel=2'b00.
3. Memory wait: mem_req=1, mem_ready low for 3 cycles → freeze for 3 cycles, mem_wb_bubble=1, stall_cnt=3. Release cycle has all enables 1.
4. Redirect during freeze: ex_redirect=1 while mem_ready=0 → no flush while frozen. On the mem_ready cycle: if_id_flush=id_ex_flush=1, flush_cnt=1.
5. Watchdog: MEM_TIMEOUT=4, mem_ready held 0 → mem_timeout pulses once on the release cycle, mem_err=1 until err_clr.
6. Reset mid-wait: drop rst_n in MWAIT → state RUN, counters 0, mem_err 0 immediately.
